ota_diff_stim_driver: RTL and testbench

//  Companion driver for the digital OTA comparator. It turns a stream of signed digital codes into a

---
 rtl/ota_diff_stim_driver.sv | 134 +++++++++++++
 tb/tb_ota_diff_stim_driver.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ota_diff_stim_driver.sv
// ota_diff_stim_driver
// Turns a stream of signed codes into a complementary 1-bit pulse-density
// pair (vip/vin) using a first-order delta-sigma modulator. Each accepted
// code is played for DWELL cycles; codes may follow back-to-back.
//
// Handshake: a code transfers on every rising edge where in_valid and
// in_ready are both high (and abort is low); in_code is sampled only on that
// edge. While in_ready is low, upstream must hold in_valid and in_code stable.
// in_ready is high in IDLE and in the last RUN cycle of a dwell, which lets a
// follow-on code start with no gap cycle.
module ota_diff_stim_driver #(
  parameter int WIDTH = 8,
  parameter int DWELL = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_code,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             abort,
  output logic             vip,
  output logic             vin,
  output logic             busy,
  output logic             sample_done
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] code_q, code_d;   // offset-binary level being played
  logic             vip_q, vip_d;
  logic             vin_q, vin_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] u_in;
  logic [WIDTH:0]   sum;
  logic             carry;
  logic             accept;
  logic             last_cnt;

  // Offset-binary mapping of the incoming code: most negative -> 0.
  assign u_in = {~in_code[WIDTH-1], in_code[WIDTH-2:0]};

  // Modulator adder; the carry out is the density bit for this cycle.
  assign sum   = {1'b0, acc_q} + {1'b0, code_q};
  assign carry = sum[WIDTH];

  assign last_cnt = (cnt_q == CNT_LAST);
  assign in_ready = (state_q == ST_IDLE) || last_cnt;
  assign accept   = in_valid && in_ready && !abort;
  assign busy     = (state_q == ST_RUN);

  assign vip         = vip_q;
  assign vin         = vin_q;
  assign sample_done = done_q;

  // Next-state logic for FSM, modulator and registered outputs.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    vip_d   = 1'b0;
    vin_d   = 1'b0;
    done_d  = 1'b0;

    if (abort) begin
      // Abort clears the dwell; the accumulator restarts from zero.
      state_d = ST_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            code_d  = u_in;
            cnt_d   = '0;
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          // acc is kept across codes so there is no bias at code boundaries.
          acc_d = sum[WIDTH-1:0];
          vip_d = carry;
          vin_d = ~carry;
          if (last_cnt) begin
            done_d = 1'b1;
            cnt_d  = '0;
            if (accept) begin
              code_d = u_in;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      code_q  <= '0;
      vip_q   <= 1'b0;
      vin_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      vip_q   <= vip_d;
      vin_q   <= vin_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_ota_diff_stim_driver.sv
// Directed bench for ota_diff_stim_driver (WIDTH=8, DWELL=16).
module tb_ota_diff_stim_driver;

  localparam int WIDTH = 8;
  localparam int DWELL = 16;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] in_code;
  logic             in_valid;
  logic             in_ready;
  logic             abort;
  logic             vip;
  logic             vin;
  logic             busy;
  logic             sample_done;

  int tests_run;
  int tests_failed;

  ota_diff_stim_driver #(.WIDTH(WIDTH), .DWELL(DWELL)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_code     (in_code),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .abort       (abort),
    .vip         (vip),
    .vin         (vin),
    .busy        (busy),
    .sample_done (sample_done)
  );

  // Clock: 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // From IDLE: present a code and let it be accepted.
  task automatic start(input logic [WIDTH-1:0] code, input string tag);
    chk({tag, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
    in_code  = code;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
  endtask

  // Called in RUN cycle cnt=0; plays one dwell, optionally chaining a code.
  task automatic dwell(input string tag, input bit chain, input logic [WIDTH-1:0] next_code,
                       output int ones, output logic [15:0] bits);
    int vin_bad;
    int ready_bad;
    int done_bad;
    ones = 0;
    bits = '0;
    vin_bad = 0;
    ready_bad = 0;
    done_bad = 0;
    for (int k = 0; k < DWELL; k++) begin
      if (busy !== 1'b1) ready_bad++;
      if (in_ready !== (k == DWELL - 1)) ready_bad++;
      if (k == DWELL - 1 && chain) begin
        in_code  = next_code;
        in_valid = 1'b1;
      end
      tick();
      in_valid = 1'b0;
      bits[k] = vip;
      if (vip === 1'b1) ones++;
      if (vin !== ~vip) vin_bad++;
      if (sample_done !== (k == DWELL - 1)) done_bad++;
    end
    chk({tag, "_vin_compl"}, vin_bad, 0);
    chk({tag, "_ready_busy"}, ready_bad, 0);
    chk({tag, "_sample_done"}, done_bad, 0);
  endtask

  initial begin
    int ones;
    logic [15:0] bits;
    int bad;

    tests_run    = 0;
    tests_failed = 0;
    rst      = 1'b0;
    in_code  = '0;
    in_valid = 1'b0;
    abort    = 1'b0;

    // Reset state, checked while rst is held.
    rst = 1'b1;
    tick();
    chk("rst_vip", {31'd0, vip}, 32'd0);
    chk("rst_vin", {31'd0, vin}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_done", {31'd0, sample_done}, 32'd0);
    rst = 1'b0;
    tick();

    // Case 1: code 0 -> alternating 0,1,0,1..., 8 ones.
    start(8'h00, "c1");
    chk("c1_first_vip_idle", {31'd0, vip}, 32'd0);
    dwell("c1", 1'b0, 8'h00, ones, bits);
    chk("c1_ones", ones, 8);
    chk("c1_bits", {16'd0, bits}, 32'h0000_AAAA);
    chk("c1_busy_after", {31'd0, busy}, 32'd0);
    chk("c1_hold_vip", {31'd0, vip}, 32'd1);
    chk("c1_hold_vin", {31'd0, vin}, 32'd0);
    tick();
    chk("c1_tail_vip", {31'd0, vip}, 32'd0);
    chk("c1_tail_vin", {31'd0, vin}, 32'd0);
    chk("c1_tail_done", {31'd0, sample_done}, 32'd0);

    // Case 2: +127 then -128 back-to-back.
    do_reset();
    start(8'h7F, "c2a");
    dwell("c2a", 1'b1, 8'h80, ones, bits);
    chk("c2a_ones", ones, 15);
    chk("c2a_bits", {16'd0, bits}, 32'h0000_FFFE);
    chk("c2_no_gap_busy", {31'd0, busy}, 32'd1);
    dwell("c2b", 1'b0, 8'h00, ones, bits);
    chk("c2b_ones", ones, 0);
    chk("c2b_bits", {16'd0, bits}, 32'h0000_0000);

    // Case 3: -64 then +64 back-to-back.
    do_reset();
    start(8'hC0, "c3a");
    dwell("c3a", 1'b1, 8'h40, ones, bits);
    chk("c3a_ones", ones, 4);
    chk("c3a_bits", {16'd0, bits}, 32'h0000_8888);
    dwell("c3b", 1'b0, 8'h00, ones, bits);
    chk("c3b_ones", ones, 12);
    chk("c3b_bits", {16'd0, bits}, 32'h0000_EEEE);

    // Case 4: in_valid raised at cnt=5; held off until cnt=15.
    do_reset();
    start(8'h00, "c4");
    bad = 0;
    for (int k = 0; k < DWELL; k++) begin
      if (k >= 5) begin
        in_valid = 1'b1;
        in_code  = (k == DWELL - 1) ? 8'hC0 : 8'(k * 7 + 1);
      end
      if (in_ready !== (k == DWELL - 1)) bad++;
      if (busy !== 1'b1) bad++;
      tick();
    end
    in_valid = 1'b0;
    chk("c4_holdoff", bad, 0);
    chk("c4_busy_chain", {31'd0, busy}, 32'd1);
    chk("c4_done", {31'd0, sample_done}, 32'd1);
    chk("c4_ready_cnt0", {31'd0, in_ready}, 32'd0);
    dwell("c4b", 1'b0, 8'h00, ones, bits);
    chk("c4b_ones", ones, 4);
    chk("c4b_bits", {16'd0, bits}, 32'h0000_8888);

    // Case 5: abort at cnt=7 of +100, then code 0 from acc=0.
    do_reset();
    start(8'h64, "c5");
    for (int k = 0; k < 7; k++) tick();
    chk("c5_ready_cnt7", {31'd0, in_ready}, 32'd0);
    abort    = 1'b1;
    in_valid = 1'b1;
    in_code  = 8'h7F;
    tick();
    abort    = 1'b0;
    in_valid = 1'b0;
    chk("c5_busy", {31'd0, busy}, 32'd0);
    chk("c5_vip", {31'd0, vip}, 32'd0);
    chk("c5_vin", {31'd0, vin}, 32'd0);
    chk("c5_done", {31'd0, sample_done}, 32'd0);
    chk("c5_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("c5_stay_idle", {31'd0, busy}, 32'd0);
    start(8'h00, "c5b");
    dwell("c5b", 1'b0, 8'h00, ones, bits);
    chk("c5b_ones", ones, 8);
    chk("c5b_bits", {16'd0, bits}, 32'h0000_AAAA);
    tick();

    // Case 6: asynchronous reset mid-RUN.
    start(8'h00, "c6");
    tick();
    tick();
    chk("c6_pre_vip", {31'd0, vip}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("c6_async_busy", {31'd0, busy}, 32'd0);
    chk("c6_async_vip", {31'd0, vip}, 32'd0);
    chk("c6_async_vin", {31'd0, vin}, 32'd0);
    chk("c6_async_ready", {31'd0, in_ready}, 32'd1);
    chk("c6_async_done", {31'd0, sample_done}, 32'd0);
    #1;
    rst = 1'b0;
    tick();
    chk("c6_post_ready", {31'd0, in_ready}, 32'd1);
    chk("c6_post_busy", {31'd0, busy}, 32'd0);
    chk("c6_post_vip", {31'd0, vip}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
